subtractor_result_stage: RTL and testbench
==========================================

// Module: subtractor_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 8-bit ripple subtractor.
//  - Captures operands A, B and the subtractor's combinational difference.
//  - Derives N/Z/C/V status flags, because the subtractor exposes no carry-out.
//  - Buffers results in a 2-entry skid FIFO behind a valid/ready handshake toward the ALU result bus.
// PARAMETERS
//  WIDTH  8  datapath width; must equal the subtractor width (only 8 supported)
//  DEPTH  2  FIFO entries; fixed at 2 (skid), other values illegal
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream offers {in_a,in_b,in_diff}
//  in_ready   out  1      stage can accept; registered, = (count != 2)
//  in_a       in   WIDTH  minuend presented to subtractor
//  in_b       in   WIDTH  subtrahend presented to subtractor
//  in_diff    in   WIDTH  subtractor Sum output (A - B mod 2^WIDTH)
//  out_valid  out  1      head entry valid, = (count != 0)
//  out_ready  in   1      downstream consumes head
//  out_diff   out  WIDTH  head difference
//  out_flags  out  4      head flags {N,Z,C,V}
//  sticky_v   out  1      [STICKY_V_EN only] sticky overflow
//  sticky_clr in   1      [STICKY_V_EN only] sync clear of sticky_v
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): count=0, ptrs=0, in_ready=1, out_valid=0,
//    out_diff=0, out_flags=0, sticky_v=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Latency: push at edge t -> out_valid=1 after edge t (visible cycle t+1) when FIFO was empty.
//  - Flags computed on push from in_a/in_b/in_diff, stored with the entry:
//    N = diff[7]; Z = (diff == 0); C = (in_a >= in_b) unsigned (1 = no borrow);
//    V = (a[7] != b[7]) & (diff[7] != a[7]).
//  - in_diff is trusted, not recomputed; flags Z/N reflect in_diff as supplied.
//  - count: push&!pop +1; pop&!push -1; push&pop unchanged (both ptrs advance).
//  - Full (count=2): in_ready=0, push impossible; pop frees a slot, in_ready=1 next cycle.
//  - Empty: out_valid=0; out_diff/out_flags hold the last popped values (0 after reset).
//  - Pointers are 1-bit and wrap 1->0.
//  - Head data must be stable while out_valid=1 & out_ready=0.
//  - in_ready depends only on state (no combinational in->out path).
//  - Reset mid-transfer: all entries discarded, no partial output.
// CONFIGURATION
//  STICKY_V_EN defined:
//    - sticky_v sets the cycle after any push with V=1.
//    - Cleared by sticky_clr (registered); set wins over clear on the same edge.
//    - Ports sticky_v and sticky_clr are present.
//  STICKY_V_EN undefined:
//    - sticky_v and sticky_clr ports and logic are absent; all other behaviour identical.
// STRUCTURE
//  - alu_pkg: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 index constants;
//    typedef struct packed {logic n,z,c,v;} alu_flags_t; ALU_WIDTH=8.
//  - One sub-module: sub_flag_gen (combinational a,b,diff -> alu_flags_t).
//  - FIFO storage and control stay inline in this module.
// TESTING
//  1 Reset: rst_n low mid-stream -> out_valid=0, in_ready=1, out_diff=0, out_flags=0 immediately.
//  2 Flags: push A=0x05 B=0x05 diff=0x00 -> out_flags=0110 (Z,C);
//    push A=0x03 B=0x05 diff=0xFE -> 1000 (N, borrow).
//  3 Overflow: A=0x80 B=0x01 diff=0x7F -> flags=0011 (C,V);
//    with STICKY_V_EN sticky_v=1 until sticky_clr.
//  4 Backpressure: out_ready=0, push 3 in a row -> only 2 accepted, in_ready=0 after 2nd;
//    release -> 0x11,0x22 in order, third accepted after the first pop.
//  5 Simultaneous: count=1, push&pop same cycle -> count stays 1, next head = new entry,
//    no drop or duplicate.
//  6 Random stream: 1000 random A/B (diff=A-B), random out_ready ->
//    scoreboard matches diff/flags, order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU result types: flag bit positions, flag struct and FIFO entry layout.
package alu_pkg;
  localparam int ALU_WIDTH = 8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] diff;
    alu_flags_t           flags;
  } res_entry_t;
endpackage

// File: rtl/sub_flag_gen.sv
// Combinational N/Z/C/V derivation for a - b, using the subtractor's own difference.
module sub_flag_gen
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [ALU_WIDTH-1:0] diff,
  output alu_flags_t           flags
);
  localparam int MSB = ALU_WIDTH - 1;

  always_comb begin
    flags   = '0;
    flags.n = diff[MSB];
    flags.z = (diff == '0);
    // C is "no borrow": the subtractor has no carry-out, so compare directly
    flags.c = (a >= b);
    flags.v = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
  end
endmodule

// File: rtl/subtractor_result_stage.sv
// Registered result stage behind the 8-bit subtractor: flags + 2-entry skid FIFO.
// Optional STICKY_V_EN adds a sticky overflow bit with synchronous clear.
module subtractor_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic [3:0]       out_flags
`ifdef STICKY_V_EN
  ,
  output logic             sticky_v,
  input  logic             sticky_clr
`endif
);
  localparam logic [1:0] FULL = 2'(DEPTH);

  res_entry_t mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt, cnt_nxt;
  logic       push, pop;
  alu_flags_t in_flags;
  res_entry_t head;

  sub_flag_gen u_flag_gen (
    .a     (in_a),
    .b     (in_b),
    .diff  (in_diff),
    .flags (in_flags)
  );

  assign push      = in_valid & in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != FULL);
      if (push) begin
        mem[wr_ptr] <= '{diff: in_diff, flags: in_flags};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // When empty the slot behind rd_ptr is the last popped entry; no push can
  // land there before the FIFO becomes non-empty again, so it holds the value.
  assign head      = out_valid ? mem[rd_ptr] : mem[~rd_ptr];
  assign out_diff  = head.diff;
  assign out_flags = head.flags;

`ifdef STICKY_V_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sticky_v <= 1'b0;
    else if (push && in_flags.v) sticky_v <= 1'b1;
    else if (sticky_clr)         sticky_v <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_subtractor_result_stage.sv
// Directed and random checks of the subtractor result stage (flags, FIFO, reset).
module tb_subtractor_result_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, in_diff, out_diff;
  logic [3:0] out_flags;
`ifdef STICKY_V_EN
  logic       sticky_v, sticky_clr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] f;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  subtractor_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_diff   (in_diff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_flags (out_flags)
`ifdef STICKY_V_EN
    ,
    .sticky_v  (sticky_v),
    .sticky_clr(sticky_clr)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_flags(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, sd;
    logic [7:0] d;
    d  = 8'(a - b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    return {d[7], d == 8'd0, int'(a) >= int'(b), (sd > 127) || (sd < -128)};
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_diff  = d;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h05, 8'h03, 8'h02);
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_diff !== 8'h00) begin errors++; $display("FAIL reset_out_diff got %h want 00", out_diff); end
    checks++;
    if (out_flags !== 4'b0000) begin errors++; $display("FAIL reset_out_flags got %b want 0000", out_flags); end
`ifdef STICKY_V_EN
    checks++;
    if (sticky_v !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", sticky_v); end
`endif
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b0;
    drive(1'b1, 8'h05, 8'h05, 8'h00);
    cyc();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flags_latency got %b want 1", out_valid); end
    checks++;
    if (out_flags !== 4'b0110) begin errors++; $display("FAIL flags_zero got %b want 0110", out_flags); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 8'h03, 8'h05, 8'hFE);
    cyc();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (out_diff !== 8'hFE) begin errors++; $display("FAIL flags_borrow_diff got %h want fe", out_diff); end
    checks++;
    if (out_flags !== 4'b1000) begin errors++; $display("FAIL flags_borrow got %b want 1000", out_flags); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_diff !== 8'hFE || out_flags !== 4'b1000) begin
      errors++;
      $display("FAIL flags_hold got v=%b d=%h f=%b want v=0 d=fe f=1000", out_valid, out_diff, out_flags);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    drive(1'b1, 8'h80, 8'h01, 8'h7F);
    cyc();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (out_flags !== 4'b0011) begin errors++; $display("FAIL ovf_flags got %b want 0011", out_flags); end
`ifdef STICKY_V_EN
    checks++;
    if (sticky_v !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set got %b want 1", sticky_v); end
`endif
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
`ifdef STICKY_V_EN
    checks++;
    if (sticky_v !== 1'b1) begin errors++; $display("FAIL ovf_sticky_hold got %b want 1", sticky_v); end
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    checks++;
    if (sticky_v !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clr got %b want 0", sticky_v); end
    // set and clear on the same edge: set wins
    sticky_clr = 1'b1;
    drive(1'b1, 8'h7F, 8'hFF, 8'h80);
    cyc();
    sticky_clr = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (sticky_v !== 1'b1) begin errors++; $display("FAIL ovf_sticky_setwins got %b want 1", sticky_v); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h00, 8'h11);
    cyc();
    drive(1'b1, 8'h22, 8'h00, 8'h22);
    cyc();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    drive(1'b1, 8'h33, 8'h00, 8'h33);
    cyc();
    checks++;
    if (out_diff !== 8'h11 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got d=%h rdy=%b want d=11 rdy=0", out_diff, in_ready);
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_diff !== 8'h22 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_pop got d=%h rdy=%b want d=22 rdy=1", out_diff, in_ready);
    end
    cyc();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (out_valid !== 1'b1 || out_diff !== 8'h33 || out_flags !== 4'b0010) begin
      errors++;
      $display("FAIL bp_third got v=%b d=%h f=%b want v=1 d=33 f=0010", out_valid, out_diff, out_flags);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_diff !== 8'h33) begin
      errors++;
      $display("FAIL bp_drain got v=%b d=%h want v=0 d=33", out_valid, out_diff);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive(1'b1, 8'h44, 8'h00, 8'h44);
    cyc();
    drive(1'b1, 8'h55, 8'h00, 8'h55);
    out_ready = 1'b1;
    cyc();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_diff !== 8'h55 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_head got v=%b d=%h rdy=%b want v=1 d=55 rdy=1", out_valid, out_diff, in_ready);
    end
    cyc();
    checks++;
    if (out_diff !== 8'h55) begin errors++; $display("FAIL simul_stable got %h want 55", out_diff); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    int pushed = 0;
    int cycles = 0;
    logic [7:0] a, b;
    q.delete();
    while (pushed < 1000 && cycles < 8000) begin
      a = 8'($urandom);
      b = 8'($urandom);
      drive($urandom_range(3, 0) != 0, a, b, 8'(a - b));
      out_ready = $urandom_range(1, 0) == 1;
      checks++;
      if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_hs got rdy=%b v=%b want occupancy %0d", in_ready, out_valid, q.size());
      end
      if (out_valid && out_ready && q.size() > 0) begin
        checks++;
        if (out_diff !== q[0].d || out_flags !== q[0].f) begin
          errors++;
          $display("FAIL rand_data got d=%h f=%b want d=%h f=%b", out_diff, out_flags, q[0].d, q[0].f);
        end
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back('{d: 8'(a - b), f: model_flags(a, b)});
        pushed++;
      end
      cyc();
      cycles++;
    end
    checks++;
    if (pushed != 1000) begin errors++; $display("FAIL rand_budget got %0d pushes want 1000", pushed); end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_diff !== q[0].d || out_flags !== q[0].f) begin
        errors++;
        $display("FAIL rand_drain got v=%b d=%h f=%b want v=1 d=%h f=%b",
                 out_valid, out_diff, out_flags, q[0].d, q[0].f);
      end
      void'(q.pop_front());
      cyc();
    end
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_empty got v=%b left=%0d want v=0 left=0", out_valid, q.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
`ifdef STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_flags();
    test_overflow();
    test_backpressure();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
